// File: rtl/alu_result_checker.sv
// Response checker for the 6-bit ALU: golden-model compare, saturating pass/fail counters,
// sticky error and first-mismatch snapshot. Optional halt-on-error via `ALU_CHK_HALT_EN.
module alu_result_checker #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       fxn,
   input  logic [WIDTH-1:0] x_dut,
   input  logic             clear,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_sticky,
   output logic             mismatch_pulse,
   output logic [2:0]       ff_fxn,
   output logic [WIDTH-1:0] ff_exp,
   output logic [WIDTH-1:0] ff_got
);

   typedef enum logic [1:0] {StIdle, StCheck, StUpdate} state_t;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, x_q, exp_q, exp_c;
   logic [2:0]       fxn_q;
   logic             mis_q;
   logic             halted;
   logic             transfer;

`ifdef ALU_CHK_HALT_EN
   assign halted = err_sticky;
`else
   assign halted = 1'b0;
`endif

   assign in_ready = (state_q == StIdle) && !halted;
   // clear blocks acceptance even when in_ready is high
   assign transfer = in_valid && in_ready && !clear;

   always_comb begin
      exp_c = '0;
      unique case (fxn_q)
         3'b000:  exp_c = a_q + b_q;
         3'b001:  exp_c = a_q - b_q;
         3'b010:  exp_c = a_q & b_q;
         3'b011:  exp_c = a_q | b_q;
         3'b100:  exp_c = a_q ^ b_q;
         3'b101:  exp_c = ~a_q;
         3'b110:  exp_c = {a_q[WIDTH-2:0], 1'b0};
         default: exp_c = {1'b0, a_q[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         a_q            <= '0;
         b_q            <= '0;
         x_q            <= '0;
         fxn_q          <= '0;
         exp_q          <= '0;
         mis_q          <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         err_sticky     <= 1'b0;
         mismatch_pulse <= 1'b0;
         ff_fxn         <= '0;
         ff_exp         <= '0;
         ff_got         <= '0;
      end else if (clear) begin
         state_q        <= StIdle;
         mis_q          <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         err_sticky     <= 1'b0;
         mismatch_pulse <= 1'b0;
         ff_fxn         <= '0;
         ff_exp         <= '0;
         ff_got         <= '0;
      end else begin
         mismatch_pulse <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (transfer) begin
                  a_q     <= a;
                  b_q     <= b;
                  fxn_q   <= fxn;
                  x_q     <= x_dut;
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               exp_q   <= exp_c;
               mis_q   <= (exp_c != x_q);
               state_q <= StUpdate;
            end
            StUpdate: begin
               if (mis_q) begin
                  if (fail_cnt != CntMax) fail_cnt <= fail_cnt + 1'b1;
                  mismatch_pulse <= 1'b1;
                  err_sticky     <= 1'b1;
                  // snapshot only the first mismatch since the last clear/reset
                  if (!err_sticky) begin
                     ff_fxn <= fxn_q;
                     ff_exp <= exp_q;
                     ff_got <= x_q;
                  end
               end else if (pass_cnt != CntMax) begin
                  pass_cnt <= pass_cnt + 1'b1;
               end
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed self-checking bench for alu_result_checker; expectations follow `ALU_CHK_HALT_EN.
module tb_alu_result_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [5:0] a = '0, b = '0, x_dut = '0;
   logic [2:0] fxn = '0;
   logic       clear = 1'b0;
   logic [7:0] pass_cnt, fail_cnt;
   logic       err_sticky, mismatch_pulse;
   logic [2:0] ff_fxn;
   logic [5:0] ff_exp, ff_got;

   int n_chk = 0;
   int n_fail = 0;
   int pulse_cnt = 0;
   int p0;

   always #5 clk = ~clk;

   alu_result_checker #(.WIDTH(6), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .fxn(fxn), .x_dut(x_dut), .clear(clear),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_sticky(err_sticky),
      .mismatch_pulse(mismatch_pulse), .ff_fxn(ff_fxn), .ff_exp(ff_exp), .ff_got(ff_got)
   );

   always @(posedge clk) if (mismatch_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One full transaction; optionally corrupts the inputs while the checker is busy.
   task automatic txn(input logic [5:0] ta, input logic [5:0] tb_, input logic [2:0] tf,
                      input logic [5:0] tx, input bit corrupt);
      int k = 0;
      while (in_ready !== 1'b1 && k < 20) begin
         @(posedge clk); #1; k++;
      end
      if (in_ready !== 1'b1) chk("ready_timeout", {31'b0, in_ready}, 1);
      a = ta; b = tb_; fxn = tf; x_dut = tx; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (corrupt) begin
         a = ~ta; x_dut = ~tx; fxn = tf + 3'd1;
      end
      @(posedge clk); @(posedge clk); #1;
   endtask

   initial begin
      // T1 reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_fail", fail_cnt, 0);
      chk("rst_err", err_sticky, 0);
      chk("rst_pulse", mismatch_pulse, 0);
      chk("rst_ff", {ff_fxn, ff_exp, ff_got}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready", in_ready, 1);

      // T2 pass sweep, A=1 B=63
      txn(6'd1, 6'd63, 3'd0, 6'd0, 0);
      chk("lat_pass1", pass_cnt, 1);
      txn(6'd1, 6'd63, 3'd1, 6'd2, 0);
      txn(6'd1, 6'd63, 3'd2, 6'd1, 0);
      txn(6'd1, 6'd63, 3'd3, 6'd63, 0);
      txn(6'd1, 6'd63, 3'd4, 6'd62, 0);
      txn(6'd1, 6'd63, 3'd5, 6'd62, 0);
      txn(6'd1, 6'd63, 3'd6, 6'd2, 0);
      txn(6'd1, 6'd63, 3'd7, 6'd0, 0);
      chk("sweep_pass", pass_cnt, 8);
      chk("sweep_fail", fail_cnt, 0);
      // inputs changing while busy must be ignored: 40+20=60
      txn(6'd40, 6'd20, 3'd0, 6'd60, 1);
      chk("busy_ignore_pass", pass_cnt, 9);
      chk("busy_ignore_fail", fail_cnt, 0);
      txn(6'd37, 6'd0, 3'd6, 6'd10, 0);   // 100101<<1 = 001010
      chk("shl_pass", pass_cnt, 10);

      // clear with in_valid in the same cycle: no transfer
      @(negedge clk);
      a = 6'd1; b = 6'd1; fxn = 3'd0; x_dut = 6'd0; in_valid = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; clear = 1'b0;
      chk("clr_no_xfer_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("clr_no_xfer_fail", fail_cnt, 0);
      chk("clr_zero_pass", pass_cnt, 0);

      // T3 first-fail capture
      p0 = pulse_cnt;
      txn(6'd1, 6'd63, 3'd0, 6'd1, 0);
      chk("t3_pulse_hi", mismatch_pulse, 1);
      chk("t3_fail1", fail_cnt, 1);
      chk("t3_err", err_sticky, 1);
      @(posedge clk); #1;
      chk("t3_pulse_lo", mismatch_pulse, 0);
`ifndef ALU_CHK_HALT_EN
      txn(6'd1, 6'd63, 3'd3, 6'd0, 0);
      @(posedge clk); #1;
      chk("t3_fail2", fail_cnt, 2);
      chk("t3_pulses", pulse_cnt - p0, 2);
`else
      chk("t3_pulses", pulse_cnt - p0, 1);
`endif
      chk("t3_ff_fxn", ff_fxn, 0);
      chk("t3_ff_exp", ff_exp, 0);
      chk("t3_ff_got", ff_got, 1);

      // T4 saturation
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      for (int i = 0; i < 260; i++) begin
         txn(i[5:0], i[5:0], 3'd2, i[5:0], 0);
         if (i == 254) chk("sat_255", pass_cnt, 255);
      end
      chk("sat_hold", pass_cnt, 255);
      chk("sat_fail", fail_cnt, 0);

      // T5 clear in CHECK cycle of a mismatching transaction
      p0 = pulse_cnt;
      @(negedge clk);
      a = 6'd5; b = 6'd3; fxn = 3'd0; x_dut = 6'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("t5_ready", in_ready, 1);
      chk("t5_pass", pass_cnt, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_fail", fail_cnt, 0);
      chk("t5_err", err_sticky, 0);
      chk("t5_pulses", pulse_cnt - p0, 0);

      // T6 mismatch, then in_valid held across three passing slots
      txn(6'd7, 6'd1, 3'd4, 6'd0, 0);     // exp 6
      chk("t6_fail_first", fail_cnt, 1);
      @(negedge clk);
      a = 6'd7; b = 6'd1; fxn = 3'd1; x_dut = 6'd6; in_valid = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t6_fail", fail_cnt, 1);
`ifdef ALU_CHK_HALT_EN
      chk("t6_pass", pass_cnt, 0);
      chk("t6_halt_ready", in_ready, 0);
`else
      chk("t6_pass", pass_cnt, 3);
      chk("t6_run_ready", in_ready, 1);
`endif
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      #1;
      chk("t6_clear_ready", in_ready, 1);
      chk("t6_clear_err", err_sticky, 0);

      // reset mid-operation
      @(negedge clk);
      a = 6'd2; b = 6'd2; fxn = 3'd0; x_dut = 6'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b0;
      #2;
      chk("midrst_ready", in_ready, 1);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_pass", pass_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
